act_collector: RTL
==================

# act_collector

Sink end of the activation output interface. Accepts up to 17 parallel activation lanes: 16 convolution lanes with addresses, plus 1 fully-connected lane without an address. Each lane is buffered in a small per-lane FIFO. A round-robin arbiter serializes the buffered results onto a single output-buffer write port, and the block reports layer completion once every enabled lane has delivered its last beat.

## Interface
- LANE_NUM, 17, total lanes; lanes 0..LANE_NUM-2 are conv lanes, lane LANE_NUM-1 is the FC lane
- ADDRESS_WIDTH, 10, conv result address width
- DATA_WIDTH, 8, activation data width
- FIFO_DEPTH, 4, entries per lane FIFO (power of two)

Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; flushes all state and begins a new layer
- lane_en_i  in  LANE_NUM  lanes participating in the layer; sampled on start_i
- act_valid_i  in  1 x LANE_NUM (unpacked)  per-lane beat valid
- act_last_i  in  1 x LANE_NUM (unpacked)  final beat of the lane for this layer
- act_result_i  in  DATA_WIDTH x LANE_NUM (unpacked)  per-lane data
- act_result_address_i  in  ADDRESS_WIDTH x (LANE_NUM-1) (unpacked)  conv lane addresses
- wr_en_o  out  1  output buffer write strobe
- wr_lane_o  out  5  source lane of the write
- wr_addr_o  out  ADDRESS_WIDTH  write address
- wr_data_o  out  DATA_WIDTH  write data
- wr_last_o  out  1  written beat carried last
- busy_o  out  1  layer in progress
- done_o  out  1  one-cycle completion pulse
- overflow_o  out  1  sticky; a beat was dropped

## Operation
- **Idle state.** After reset, busy_o=0 and inputs are ignored.
- **start_i.** Clears all FIFOs, last flags, the FC address counter, the arbiter pointer (to 0) and overflow_o. Latches lane_en_i and sets busy_o=1.
- **Entry capture.**
  - Disabled lanes are ignored entirely.
  - Each enabled lane pushes {data, addr, last} into its FIFO when act_valid_i is high.
  - The conv lane address is act_result_address_i.
  - The FC lane address comes from an internal counter: 0 at start, +1 per accepted FC beat, wraps modulo 2^ADDRESS_WIDTH.
- **Push acceptance.** A push is accepted if the FIFO count < FIFO_DEPTH, or if the same FIFO is popped that cycle.
- **Overflow.** A push that is not accepted drops the beat and sets overflow_o. That beat is never written. If it carried last, the last flag is still recorded so completion can occur.
- **Arbitration.**
  - Each cycle, at most one non-empty FIFO is granted, round-robin.
  - The search starts at the lane after the previously granted lane, wrapping from LANE_NUM-1 to 0.
  - The granted entry is popped and registered onto the wr_* outputs.
- **Last tracking.** A lane's done flag is set when an entry with last=1 is popped (or dropped on overflow).
- **Completion.** When every enabled lane's done flag is set and all FIFOs are empty:
  - done_o pulses for one cycle;
  - busy_o falls in the same cycle;
  - the block returns to idle.
- **Empty layer.** If lane_en_i = 0 at start_i, done_o pulses on the cycle after start_i.
- **Restart.** start_i while busy aborts the current layer: same flush as above, and no done_o for the aborted layer.
- **Rogue beats.** Beats arriving on a lane after its done flag is set are dropped and set overflow_o.

## Timing
- **Reset values.** All outputs are 0 at reset: wr_en_o, wr_lane_o, wr_addr_o, wr_data_o, wr_last_o, busy_o, done_o, overflow_o.
- **Latency.** A beat accepted at edge N, into an empty FIFO and granted immediately, appears with wr_en_o=1 in the cycle after edge N+1. Minimum input-to-write latency is 2 cycles.
- **Throughput.** One write per cycle total. wr_en_o is 0 in any cycle with no grant, and the other wr_* outputs hold their previous values.
- **done_o timing.** done_o asserts in the cycle after the final popped entry's write strobe. It never coincides with a wr_en_o strobe of the same layer.
- **start_i vs. inputs.** start_i takes priority over a same-cycle act_valid_i: that beat is dropped and overflow_o is not set.
- **Reset mid-operation.** Asynchronous rst immediately forces all outputs to 0 and discards all buffered data.

## Test plan
- **Single lane.** start with lane_en=17'h00001; lane 0 sends beats (addr 5, data 8'h11) then (addr 6, data 8'h22, last) -> writes lane 0/addr 5/8'h11, then addr 6/8'h22 with wr_last=1; done_o pulses once, 1 cycle after that write.
- **All lanes simultaneous.** All 17 lanes valid in one cycle with data = lane index -> 17 consecutive writes in lane order 0..16, FC write at addr 0, overflow_o=0.
- **Round-robin fairness.** Lanes 2 and 9 each stream 8 beats continuously -> writes alternate 2,9,2,9…; FIFOs fill, and overflow_o=1 once the input rate exceeds the 1/2 drain rate.
- **FC address counter.** lane_en=1<<16; FC sends 1030 beats -> wr_addr_o counts 0..1023, then wraps to 0..5; done_o after the last beat.
- **Abort and empty layer.** start_i mid-layer with 3 entries buffered -> those entries are never written and no done_o is issued for the aborted layer. A following start_i with lane_en=0 -> done_o exactly 1 cycle later.
- **Reset mid-operation.** Assert rst while busy with full FIFOs -> all outputs 0 immediately; no writes after release until a new start_i.

Source files
------------

// File: rtl/act_collector.sv
// Activation collector: buffers up to LANE_NUM result lanes in per-lane FIFOs and
// serializes them round-robin onto one output-buffer write port with layer completion.
module act_collector #(
  parameter int LANE_NUM      = 17,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [LANE_NUM-1:0]      lane_en_i,
  input  logic                     act_valid_i          [LANE_NUM],
  input  logic                     act_last_i           [LANE_NUM],
  input  logic [DATA_WIDTH-1:0]    act_result_i         [LANE_NUM],
  input  logic [ADDRESS_WIDTH-1:0] act_result_address_i [LANE_NUM-1],
  output logic                     wr_en_o,
  output logic [4:0]               wr_lane_o,
  output logic [ADDRESS_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]    wr_data_o,
  output logic                     wr_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overflow_o
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W  = 5;
  localparam int FC_LANE = LANE_NUM - 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]    mem_data [LANE_NUM][FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_addr [LANE_NUM][FIFO_DEPTH];
  logic                     mem_last [LANE_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr   [LANE_NUM];
  logic [PTR_W-1:0]         rd_ptr   [LANE_NUM];
  logic [CNT_W-1:0]         count    [LANE_NUM];
  logic [ADDRESS_WIDTH-1:0] lane_addr [LANE_NUM];

  logic [LANE_NUM-1:0]      lane_en_q;
  logic [LANE_NUM-1:0]      done_flag;
  logic [LANE_NUM-1:0]      empty;
  logic [LANE_NUM-1:0]      push_req;
  logic [LANE_NUM-1:0]      push_ok;
  logic [LANE_NUM-1:0]      drop;
  logic [LANE_NUM-1:0]      pop;

  logic [LANE_W-1:0]        rr_ptr;
  logic [LANE_W-1:0]        arb_idx;
  logic [LANE_W-1:0]        grant_idx;
  logic                     grant_vld;
  logic [ADDRESS_WIDTH-1:0] fc_addr;
  logic                     busy;
  logic                     layer_complete;
  logic                     done_d;

  assign busy   = (state_q == ST_ACTIVE);
  assign busy_o = busy;

  // The FC lane carries no address; it is numbered by an internal beat counter.
  for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane_addr
    if (g == FC_LANE) begin : g_fc
      assign lane_addr[g] = fc_addr;
    end else begin : g_conv
      assign lane_addr[g] = act_result_address_i[g];
    end
  end

  always_comb begin
    for (int i = 0; i < LANE_NUM; i++) begin
      empty[i] = (count[i] == '0);
    end
  end

  // Round-robin search begins at rr_ptr, the lane following the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = '0;
    for (int k = 0; k < LANE_NUM; k++) begin
      arb_idx = LANE_W'((int'(rr_ptr) + k) % LANE_NUM);
      if (!grant_vld && busy && !empty[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = arb_idx;
      end
    end
  end

  // A push into a full FIFO still succeeds when that FIFO is popped in the same cycle.
  always_comb begin
    pop      = '0;
    push_req = '0;
    push_ok  = '0;
    drop     = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      pop[i]      = grant_vld && !start_i && (grant_idx == LANE_W'(i));
      push_req[i] = busy && !start_i && lane_en_q[i] && act_valid_i[i];
      push_ok[i]  = push_req[i] && !done_flag[i] &&
                    ((count[i] < CNT_W'(FIFO_DEPTH)) || pop[i]);
      drop[i]     = push_req[i] && !push_ok[i];
    end
  end

  assign layer_complete = (&(done_flag | ~lane_en_q)) && (&empty);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (start_i) begin
      state_d = (|lane_en_i) ? ST_ACTIVE : ST_IDLE;
      done_d  = ~|lane_en_i;
    end else if (busy && layer_complete) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANE_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      done_flag <= '0;
    end else if (start_i) begin
      for (int i = 0; i < LANE_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      done_flag <= '0;
    end else begin
      for (int i = 0; i < LANE_NUM; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
        // A dropped last beat still closes the lane so the layer can finish.
        done_flag[i] <= done_flag[i] | (pop[i] & mem_last[i][rd_ptr[i]])
                                     | (drop[i] & act_last_i[i]);
      end
    end
  end

  // NOTE: FIFO storage has no reset; pointers and counts alone define validity,
  // so clearing them discards every buffered entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_NUM; i++) begin
      if (push_ok[i]) begin
        mem_data[i][wr_ptr[i]] <= act_result_i[i];
        mem_addr[i][wr_ptr[i]] <= lane_addr[i];
        mem_last[i][wr_ptr[i]] <= act_last_i[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_o     <= 1'b0;
      lane_en_q  <= '0;
      rr_ptr     <= '0;
      fc_addr    <= '0;
      overflow_o <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_lane_o  <= '0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      wr_last_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= done_d;
      wr_en_o <= grant_vld && !start_i;
      if (start_i) begin
        lane_en_q  <= lane_en_i;
        rr_ptr     <= '0;
        fc_addr    <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (grant_vld) begin
          wr_lane_o <= grant_idx;
          wr_addr_o <= mem_addr[grant_idx][rd_ptr[grant_idx]];
          wr_data_o <= mem_data[grant_idx][rd_ptr[grant_idx]];
          wr_last_o <= mem_last[grant_idx][rd_ptr[grant_idx]];
          rr_ptr    <= (grant_idx == LANE_W'(FC_LANE)) ? '0 : grant_idx + LANE_W'(1);
        end
        if (push_ok[FC_LANE]) fc_addr <= fc_addr + ADDRESS_WIDTH'(1);
        if (|drop) overflow_o <= 1'b1;
      end
    end
  end

endmodule
